// File: rtl/snake_body_if.sv
// Handshake/bus bundle for snake_body: control strobes in, grid and head state out.
interface snake_body_if;
    logic                   start;
    logic                   step;
    logic [1:0]             dir;
    logic                   eaten;
    logic [15:0][15:0]      lights;
    logic [3:0]             head_x;
    logic [3:0]             head_y;
    logic [7:0]             length;
    logic                   game_over;

    modport master (
        output start, step, dir, eaten,
        input  lights, head_x, head_y, length, game_over
    );

    modport slave (
        input  start, step, dir, eaten,
        output lights, head_x, head_y, length, game_over
    );
endinterface

// File: rtl/snake_body.sv
// Snake body engine for the 16x16 playfield: per-cell life counters, head motion, growth.
// Define SNAKE_WRAP_EN to wrap the head at grid edges; otherwise leaving the grid ends the game.
module snake_body #(
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned MAX_LEN  = 255
) (
    input  logic         clk,
    input  logic         reset,
    snake_body_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [7:0] INIT_L = 8'(INIT_LEN);
    localparam logic [7:0] MAX_L  = 8'(MAX_LEN);
    localparam logic [3:0] HOME   = 4'd7;

    state_t     state;
    logic [7:0] life [16][16];
    logic [3:0] hx;
    logic [3:0] hy;
    logic [7:0] len;
    logic [1:0] cur_dir;
    logic       grow_pending;
    logic       over_q;

    logic       reversal;
    logic [1:0] mv_dir;
    logic [3:0] tx;
    logic [3:0] ty;
    logic       grow;
    logic [7:0] tgt_life;
    logic       hit;
    logic       collide;
    logic [7:0] len_nx;
    logic       reload;

    // The direction sampled on a step steers that same step.
    always_comb begin
        reversal = (bus.dir == (cur_dir ^ 2'b10)) && (len > 8'd1);
        mv_dir   = reversal ? cur_dir : bus.dir;
        tx       = hx;
        ty       = hy;
        case (mv_dir)
            2'b00:   ty = hy - 4'd1;
            2'b01:   tx = hx + 4'd1;
            2'b10:   ty = hy + 4'd1;
            default: tx = hx - 4'd1;
        endcase
        grow     = (grow_pending | bus.eaten) && (len != MAX_L);
        tgt_life = life[ty][tx];
        // A life==1 cell vacates on a non-growing step, so only >=2 blocks then.
        hit      = grow ? (tgt_life >= 8'd1) : (tgt_life >= 8'd2);
        len_nx   = grow ? len + 8'd1 : len;
        reload   = (state != RUN) && bus.start;
    end

`ifdef SNAKE_WRAP_EN
    assign collide = hit;
`else
    logic off_edge;

    always_comb begin
        case (mv_dir)
            2'b00:   off_edge = (hy == 4'd0);
            2'b01:   off_edge = (hx == 4'hF);
            2'b10:   off_edge = (hy == 4'hF);
            default: off_edge = (hx == 4'd0);
        endcase
    end

    assign collide = hit | off_edge;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hx           <= HOME;
            hy           <= HOME;
            len          <= INIT_L;
            cur_dir      <= 2'b01;
            grow_pending <= 1'b0;
            over_q       <= 1'b0;
            for (int unsigned y = 0; y < 16; y++) begin
                for (int unsigned x = 0; x < 16; x++) begin
                    life[y][x] <= ((y == 7) && (x == 7)) ? 8'd1 : '0;
                end
            end
        end else if (reload) begin
            state        <= RUN;
            hx           <= HOME;
            hy           <= HOME;
            len          <= INIT_L;
            cur_dir      <= 2'b01;
            grow_pending <= 1'b0;
            over_q       <= 1'b0;
            for (int unsigned y = 0; y < 16; y++) begin
                for (int unsigned x = 0; x < 16; x++) begin
                    life[y][x] <= ((y == 7) && (x == 7)) ? 8'd1 : '0;
                end
            end
        end else if (state == RUN) begin
            if (bus.step) begin
                if (collide) begin
                    state  <= OVER;
                    over_q <= 1'b1;
                end else begin
                    for (int unsigned y = 0; y < 16; y++) begin
                        for (int unsigned x = 0; x < 16; x++) begin
                            if ((y[3:0] == ty) && (x[3:0] == tx)) begin
                                life[y][x] <= len_nx;
                            end else if (!grow && (life[y][x] != '0)) begin
                                life[y][x] <= life[y][x] - 8'd1;
                            end
                        end
                    end
                    len     <= len_nx;
                    hx      <= tx;
                    hy      <= ty;
                    cur_dir <= mv_dir;
                    if (grow) begin
                        grow_pending <= 1'b0;
                    end
                end
            end else if (bus.eaten && (len != MAX_L)) begin
                grow_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.lights = '0;
        for (int unsigned y = 0; y < 16; y++) begin
            for (int unsigned x = 0; x < 16; x++) begin
                bus.lights[y][x] = (life[y][x] != '0);
            end
        end
    end

    assign bus.head_x    = hx;
    assign bus.head_y    = hy;
    assign bus.length    = len;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed vector table, async-reset sequence, randomized run vs a timestamp model.
module tb_snake_body;
    localparam int INIT_LEN = 3;
    localparam int MAX_LEN  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    snake_body_if bus();

    snake_body #(.INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_grid(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit st, input bit sp, input bit [1:0] d, input bit e);
        bus.start = st;
        bus.step  = sp;
        bus.dir   = d;
        bus.eaten = e;
        @(posedge clk);
        #1;
    endtask

    // Model: a cell holds an expiry time; it is lit while expiry > m_t.
    // Non-growing steps advance m_t, which ages every cell at once.
    int m_exp [16][16];
    int m_t, m_len, m_state, m_dir, m_hx, m_hy;
    bit m_gp;

    function automatic void model_reset();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                m_exp[y][x] = 0;
        m_t = 0;
        m_exp[7][7] = 1;
        m_hx = 7;
        m_hy = 7;
        m_len = INIT_LEN;
        m_gp = 0;
        m_dir = 1;
    endfunction

    function automatic void model_cycle(input bit st, input bit sp, input int d, input bit e);
        int dd, nx, ny, life;
        bit grow, off, hit;
        if (m_state != 1) begin
            if (st) begin
                model_reset();
                m_state = 1;
            end
            return;
        end
        if (!sp) begin
            if (e && m_len < MAX_LEN) m_gp = 1;
            return;
        end
        grow = (m_gp || e) && (m_len < MAX_LEN);
        dd = (d == (m_dir + 2) % 4 && m_len > 1) ? m_dir : d;
        nx = m_hx;
        ny = m_hy;
        case (dd)
            0: ny = ny - 1;
            1: nx = nx + 1;
            2: ny = ny + 1;
            default: nx = nx - 1;
        endcase
        off = (nx < 0) || (nx > 15) || (ny < 0) || (ny > 15);
        nx = (nx + 16) % 16;
        ny = (ny + 16) % 16;
        life = m_exp[ny][nx] - m_t;
        if (life < 0) life = 0;
        hit = grow ? (life >= 1) : (life >= 2);
`ifndef SNAKE_WRAP_EN
        hit = hit || off;
`endif
        if (hit) begin
            m_state = 2;
            return;
        end
        if (grow) begin
            m_len++;
            m_gp = 0;
        end else begin
            m_t++;
        end
        m_exp[ny][nx] = m_t + m_len;
        m_hx = nx;
        m_hy = ny;
        m_dir = dd;
    endfunction

    function automatic logic [255:0] model_grid();
        logic [255:0] g;
        g = '0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                g[y*16 + x] = (m_exp[y][x] > m_t);
        return g;
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_head_x"}, int'(bus.head_x), m_hx);
        check({tag, "_head_y"}, int'(bus.head_y), m_hy);
        check({tag, "_length"}, int'(bus.length), m_len);
        check({tag, "_game_over"}, int'(bus.game_over), (m_state == 2) ? 1 : 0);
        check_grid({tag, "_lights"}, bus.lights, model_grid());
    endtask

    typedef struct {
        bit       st;
        bit       sp;
        bit [1:0] d;
        bit       e;
        int       hx;
        int       hy;
        int       len;
        bit       go;
        int       lit;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit st, input bit sp, input bit [1:0] d, input bit e,
                                input int hx, input int hy, input int len, input bit go, input int lit);
        vec_t v;
        v = '{st, sp, d, e, hx, hy, len, go, lit};
        tbl.push_back(v);
    endfunction

    logic [255:0] home;
    logic [255:0] snap;

    initial begin
        bit [1:0] rd;
        bit rst_, rsp, re;

        home = '0;
        home[7*16 + 7] = 1'b1;
        bus.start = 0;
        bus.step  = 0;
        bus.dir   = 2'b01;
        bus.eaten = 0;

        #1 reset = 1'b1;
        #2;
        check("reset_head_x", int'(bus.head_x), 7);
        check("reset_head_y", int'(bus.head_y), 7);
        check("reset_length", int'(bus.length), INIT_LEN);
        check("reset_game_over", int'(bus.game_over), 0);
        check_grid("reset_lights", bus.lights, home);
        #4 reset = 1'b0;

        //   st sp dir   e   hx  hy len go lit
        add(0, 1, 2'd1, 1,  7, 7, 3, 0, 1);   // IDLE ignores step/eaten
        add(1, 0, 2'd1, 0,  7, 7, 3, 0, 1);   // start
        add(0, 1, 2'd1, 0,  8, 7, 3, 0, 1);
        add(0, 1, 2'd1, 0,  9, 7, 3, 0, 2);
        add(0, 1, 2'd1, 0, 10, 7, 3, 0, 3);
        add(0, 1, 2'd3, 0, 11, 7, 3, 0, 3);   // reversal ignored
        add(0, 0, 2'd1, 1, 11, 7, 3, 0, 3);   // eaten without step
        add(0, 0, 2'd1, 0, 11, 7, 3, 0, 3);
        add(0, 1, 2'd1, 0, 12, 7, 4, 0, 4);   // pending growth applied
        add(0, 1, 2'd1, 0, 13, 7, 4, 0, 4);
        add(0, 1, 2'd0, 1, 13, 6, 5, 0, 5);   // same-cycle eaten grows
        add(0, 1, 2'd3, 0, 12, 6, 5, 0, 5);
        add(0, 1, 2'd2, 0, 12, 6, 5, 1, 5);   // into own body
        add(0, 1, 2'd2, 1, 12, 6, 5, 1, 5);   // frozen in OVER
        add(1, 1, 2'd1, 0,  7, 7, 3, 0, 1);   // start beats step
        for (int k = 1; k <= 8; k++)
            add(0, 1, 2'd1, 0, 7 + k, 7, 3, 0, (k < 3) ? k : 3);
`ifdef SNAKE_WRAP_EN
        add(0, 1, 2'd1, 0,  0, 7, 3, 0, 3);
`else
        add(0, 1, 2'd1, 0, 15, 7, 3, 1, 3);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].d, tbl[i].e);
            check($sformatf("vec%0d_head_x", i), int'(bus.head_x), tbl[i].hx);
            check($sformatf("vec%0d_head_y", i), int'(bus.head_y), tbl[i].hy);
            check($sformatf("vec%0d_length", i), int'(bus.length), tbl[i].len);
            check($sformatf("vec%0d_game_over", i), int'(bus.game_over), int'(tbl[i].go));
            check($sformatf("vec%0d_lit", i), $countones(bus.lights), tbl[i].lit);
            if (i == 4) begin
                check("line_7_7", int'(bus.lights[7][7]), 0);
                check("line_7_8", int'(bus.lights[7][8]), 1);
                check("line_7_9", int'(bus.lights[7][9]), 1);
                check("line_7_10", int'(bus.lights[7][10]), 1);
            end
            if (i == 12) snap = bus.lights;
            if (i == 13) check_grid("over_frozen", bus.lights, snap);
            if (i == 14) check_grid("restart_lights", bus.lights, home);
        end

        // Async reset arriving while a step is being presented.
        drive(1, 0, 2'd1, 0);
        drive(0, 1, 2'd1, 0);
        drive(0, 1, 2'd1, 0);
        check("pre_abort_head_x", int'(bus.head_x), 9);
        bus.step = 1;
        #2 reset = 1'b1;
        #1;
        check("abort_head_x", int'(bus.head_x), 7);
        check("abort_length", int'(bus.length), INIT_LEN);
        check_grid("abort_lights", bus.lights, home);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle_head_x", int'(bus.head_x), 7);
        check("abort_idle_game_over", int'(bus.game_over), 0);

        // Randomized run against the model.
        model_reset();
        m_state = 0;
        rd = 2'd1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 699) == 0) begin
                #1 reset = 1'b1;
                #1;
                model_reset();
                m_state = 0;
                check_model("rnd_reset");
                reset = 1'b0;
            end
            rst_ = (m_state != 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            rsp  = $urandom_range(0, 1);
            re   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) rd = 2'($urandom_range(0, 3));
            drive(rst_, rsp, rd, re);
            model_cycle(rst_, rsp, int'(rd), re);
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
